gate_response_checker: RTL and testbench

Synthesizable response checker for the switch-level NOR and OAI gate cells; it is the observing end of the gate stimulus bench. It watches the stimulus applied to both gates and their outputs. After the stimulus has been stable for a programmable settle time, it compares each output against the gate's Boolean function. It keeps vector and error counts and captures the first failing vector, so a bench or FPGA harness reads a verdict instead of inspecting waveforms.

---
 rtl/gate_response_checker_if.sv | 34 +++
 rtl/gate_response_checker.sv | 153 +++++++++++++++
 tb/tb_gate_response_checker.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/gate_response_checker_if.sv
// Bundle of the stimulus, gate outputs and verdict signals exchanged between
// the gate stimulus bench (master) and the response checker (slave).
interface gate_response_checker_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             a1;
    logic             b1;
    logic             w1;
    logic             a2;
    logic             b2;
    logic             c2;
    logic             w2;
    logic             chk_valid;
    logic             nor_err;
    logic             oai_err;
    logic [CNT_W-1:0] vec_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             err_sticky;
    logic [4:0]       first_err_vec;
    logic             first_err_valid;

    modport master (
        output en, a1, b1, w1, a2, b2, c2, w2,
        input  chk_valid, nor_err, oai_err, vec_cnt, err_cnt,
               err_sticky, first_err_vec, first_err_valid
    );

    modport slave (
        input  en, a1, b1, w1, a2, b2, c2, w2,
        output chk_valid, nor_err, oai_err, vec_cnt, err_cnt,
               err_sticky, first_err_vec, first_err_valid
    );
endinterface

// File: rtl/gate_response_checker.sv
// Response checker for the NOR and OAI gate cells. Waits until the stimulus
// has been stable for SETTLE_CYCLES edges, compares both gate outputs with
// their Boolean functions once per vector, and keeps saturating vector/error
// counters plus a capture of the first failing vector.
module gate_response_checker #(
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_W         = 8
) (
    input logic                  clk,
    input logic                  rst,
    gate_response_checker_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        HOLD
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    state_t           state;
    state_t           state_d;
    logic [7:0]       scnt;
    logic [7:0]       scnt_d;
    logic [4:0]       in_vec;
    logic [4:0]       in_q;
    logic             change;
    logic             exp1;
    logic             exp2;
    logic             mis1;
    logic             mis2;
    logic             do_check;

    logic             chk_valid_q;
    logic             nor_err_q;
    logic             oai_err_q;
    logic [CNT_W-1:0] vec_cnt_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic             err_sticky_q;
    logic [4:0]       first_err_vec_q;
    logic             first_err_valid_q;

    assign in_vec = {bus.a1, bus.b1, bus.a2, bus.b2, bus.c2};
    assign change = (in_vec != in_q);
    assign exp1   = ~(bus.a1 | bus.b1);
    assign exp2   = ~((bus.a2 | bus.b2) & bus.c2);
    assign mis1   = (bus.w1 != exp1);
    assign mis2   = (bus.w2 != exp2);

    // State, settle counter and the previous-vector register that change detection compares against.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            scnt  <= 8'd0;
            in_q  <= 5'd0;
        end else begin
            state <= state_d;
            scnt  <= scnt_d;
            in_q  <= in_vec;
        end
    end

    // Next state: disabling wins over everything; any sampled change restarts the settle window.
    always_comb begin
        state_d  = state;
        scnt_d   = scnt;
        do_check = 1'b0;
        if (!bus.en) begin
            state_d = IDLE;
            scnt_d  = 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    state_d = SETTLE;
                    scnt_d  = 8'd0;
                end
                SETTLE: begin
                    if (change) begin
                        scnt_d = 8'd0;
                    end else if (scnt == SETTLE_LAST) begin
                        state_d = CHECK;
                    end else begin
                        scnt_d = scnt + 8'd1;
                    end
                end
                CHECK: begin
                    if (change) begin
                        state_d = SETTLE;
                        scnt_d  = 8'd0;
                    end else begin
                        do_check = 1'b1;
                        state_d  = HOLD;
                    end
                end
                HOLD: begin
                    if (change) begin
                        state_d = SETTLE;
                        scnt_d  = 8'd0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    scnt_d  = 8'd0;
                end
            endcase
        end
    end

    // Verdict pulse, saturating counters and first-failure capture, all updated on a completed check.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_valid_q       <= 1'b0;
            nor_err_q         <= 1'b0;
            oai_err_q         <= 1'b0;
            vec_cnt_q         <= '0;
            err_cnt_q         <= '0;
            err_sticky_q      <= 1'b0;
            first_err_vec_q   <= 5'd0;
            first_err_valid_q <= 1'b0;
        end else begin
            chk_valid_q <= do_check;
            nor_err_q   <= do_check & mis1;
            oai_err_q   <= do_check & mis2;
            if (do_check) begin
                if (vec_cnt_q != '1) begin
                    vec_cnt_q <= vec_cnt_q + 1'b1;
                end
                if (mis1 | mis2) begin
                    if (err_cnt_q != '1) begin
                        err_cnt_q <= err_cnt_q + 1'b1;
                    end
                    err_sticky_q <= 1'b1;
                    if (!first_err_valid_q) begin
                        first_err_vec_q   <= in_vec;
                        first_err_valid_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.chk_valid       = chk_valid_q;
    assign bus.nor_err         = nor_err_q;
    assign bus.oai_err         = oai_err_q;
    assign bus.vec_cnt         = vec_cnt_q;
    assign bus.err_cnt         = err_cnt_q;
    assign bus.err_sticky      = err_sticky_q;
    assign bus.first_err_vec   = first_err_vec_q;
    assign bus.first_err_valid = first_err_valid_q;

endmodule

// File: tb/tb_gate_response_checker.sv
// Self-checking bench for gate_response_checker: a table of vectors with
// hand-computed verdicts, plus directed sequences for glitching stimulus,
// enable drop in the check cycle, reset mid-settle and counter saturation.
module tb_gate_response_checker;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    gate_response_checker_if #(.CNT_W(8)) bus8 ();
    gate_response_checker_if #(.CNT_W(2)) bus2 ();

    gate_response_checker #(.SETTLE_CYCLES(8), .CNT_W(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    gate_response_checker #(.SETTLE_CYCLES(3), .CNT_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    typedef struct {
        logic [4:0] vec;
        logic       w1;
        logic       w2;
        logic       expNor;
        logic       expOai;
        logic [7:0] expVec;
        logic [7:0] expErr;
        logic       expSticky;
    } vec_rec_t;

    vec_rec_t tbl [8];

    int testsRun    = 0;
    int testsFailed = 0;

    // Compare one observed value with its expected value and log mismatches.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drive a new stimulus vector and gate outputs on the falling edge.
    task automatic applyStimulus(input logic [4:0] vec, input logic w1v, input logic w2v);
        @(negedge clk);
        {bus8.a1, bus8.b1, bus8.a2, bus8.b2, bus8.c2} = vec;
        bus8.w1 = w1v;
        bus8.w2 = w2v;
    endtask

    // Observe a number of rising edges of dut8 and summarise the chk_valid pulses seen.
    task automatic watchPulses(input int edges, output int count, output int firstIdx,
                               output logic norSeen, output logic oaiSeen, output logic stray);
        count    = 0;
        firstIdx = -1;
        norSeen  = 1'b0;
        oaiSeen  = 1'b0;
        stray    = 1'b0;
        for (int i = 0; i < edges; i++) begin
            @(posedge clk);
            #1;
            if (bus8.chk_valid) begin
                count++;
                if (firstIdx < 0) firstIdx = i;
                norSeen = bus8.nor_err;
                oaiSeen = bus8.oai_err;
            end else if (bus8.nor_err || bus8.oai_err) begin
                stray = 1'b1;
            end
        end
    endtask

    initial begin
        int   cnt;
        int   idx;
        logic nr;
        logic oa;
        logic st;
        int   pulsesDuring;
        logic [4:0] vec2 [5];
        logic       w1b  [5];

        //            vec       w1    w2    nor   oai   vec    err    sticky
        tbl[0] = '{5'b10011, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1, 8'd0, 1'b0};
        tbl[1] = '{5'b01100, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 8'd0, 1'b0};
        tbl[2] = '{5'b00110, 1'b1, 1'b1, 1'b0, 1'b0, 8'd3, 8'd0, 1'b0};
        tbl[3] = '{5'b10111, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4, 8'd0, 1'b0};
        tbl[4] = '{5'b00001, 1'b1, 1'b1, 1'b0, 1'b0, 8'd5, 8'd0, 1'b0};
        tbl[5] = '{5'b00101, 1'b1, 1'b0, 1'b0, 1'b0, 8'd6, 8'd0, 1'b0};
        tbl[6] = '{5'b00110, 1'b0, 1'b1, 1'b1, 1'b0, 8'd7, 8'd1, 1'b1};
        tbl[7] = '{5'b10111, 1'b0, 1'b1, 1'b0, 1'b1, 8'd8, 8'd2, 1'b1};

        rst = 1'b1;
        {bus8.en, bus8.a1, bus8.b1, bus8.w1, bus8.a2, bus8.b2, bus8.c2, bus8.w2} = 8'd0;
        {bus2.en, bus2.a1, bus2.b1, bus2.w1, bus2.a2, bus2.b2, bus2.c2, bus2.w2} = 8'd0;
        #12;
        checkOutput("reset chk_valid", 32'(bus8.chk_valid), 32'd0);
        checkOutput("reset nor_err", 32'(bus8.nor_err), 32'd0);
        checkOutput("reset oai_err", 32'(bus8.oai_err), 32'd0);
        checkOutput("reset vec_cnt", 32'(bus8.vec_cnt), 32'd0);
        checkOutput("reset err_cnt", 32'(bus8.err_cnt), 32'd0);
        checkOutput("reset err_sticky", 32'(bus8.err_sticky), 32'd0);
        checkOutput("reset first_err_vec", 32'(bus8.first_err_vec), 32'd0);
        checkOutput("reset first_err_valid", 32'(bus8.first_err_valid), 32'd0);

        @(negedge clk);
        rst     = 1'b0;
        bus8.en = 1'b1;

        // Table-driven vectors, each held for 12 edges; the pulse lands 9 edges after the change.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(tbl[i].vec, tbl[i].w1, tbl[i].w2);
            watchPulses(12, cnt, idx, nr, oa, st);
            checkOutput($sformatf("row%0d pulse count", i), 32'(cnt), 32'd1);
            checkOutput($sformatf("row%0d pulse edge", i), 32'(idx), 32'd9);
            checkOutput($sformatf("row%0d nor_err", i), 32'(nr), 32'(tbl[i].expNor));
            checkOutput($sformatf("row%0d oai_err", i), 32'(oa), 32'(tbl[i].expOai));
            checkOutput($sformatf("row%0d stray err", i), 32'(st), 32'd0);
            checkOutput($sformatf("row%0d vec_cnt", i), 32'(bus8.vec_cnt), 32'(tbl[i].expVec));
            checkOutput($sformatf("row%0d err_cnt", i), 32'(bus8.err_cnt), 32'(tbl[i].expErr));
            checkOutput($sformatf("row%0d err_sticky", i), 32'(bus8.err_sticky), 32'(tbl[i].expSticky));
        end
        checkOutput("first_err_vec", 32'(bus8.first_err_vec), 32'(5'b00110));
        checkOutput("first_err_valid", 32'(bus8.first_err_valid), 32'd1);

        // b2 toggling every 5 edges never lets the 8-edge settle window complete.
        pulsesDuring = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (t == 0) begin
                {bus8.a1, bus8.b1, bus8.a2, bus8.b2, bus8.c2} = 5'b00101;
                bus8.w1 = 1'b1;
                bus8.w2 = 1'b0;
            end else if (t % 5 == 0) begin
                bus8.b2 = ~bus8.b2;
            end
            @(posedge clk);
            #1;
            if (bus8.chk_valid) pulsesDuring++;
        end
        watchPulses(12, cnt, idx, nr, oa, st);
        checkOutput("toggle no pulse", 32'(pulsesDuring), 32'd0);
        checkOutput("toggle final count", 32'(cnt), 32'd1);
        checkOutput("toggle final edge", 32'(idx), 32'd4);
        checkOutput("toggle errs", 32'({nr, oa, st}), 32'd0);
        checkOutput("toggle vec_cnt", 32'(bus8.vec_cnt), 32'd9);
        checkOutput("toggle err_cnt", 32'(bus8.err_cnt), 32'd2);

        // Dropping en during the CHECK cycle discards the check.
        applyStimulus(5'b10011, 1'b0, 1'b0);
        watchPulses(9, cnt, idx, nr, oa, st);
        checkOutput("en drop pre pulse", 32'(cnt), 32'd0);
        @(negedge clk);
        bus8.en = 1'b0;
        watchPulses(6, cnt, idx, nr, oa, st);
        checkOutput("en drop pulse", 32'(cnt), 32'd0);
        checkOutput("en drop vec_cnt", 32'(bus8.vec_cnt), 32'd9);
        checkOutput("en drop err_cnt", 32'(bus8.err_cnt), 32'd2);
        @(negedge clk);
        bus8.en = 1'b1;
        watchPulses(12, cnt, idx, nr, oa, st);
        checkOutput("re-enable count", 32'(cnt), 32'd1);
        checkOutput("re-enable edge", 32'(idx), 32'd9);
        checkOutput("re-enable vec_cnt", 32'(bus8.vec_cnt), 32'd10);

        // Reset in the middle of a settle window: no pulse, everything cleared.
        applyStimulus(5'b01100, 1'b0, 1'b1);
        watchPulses(4, cnt, idx, nr, oa, st);
        checkOutput("rst pre pulse", 32'(cnt), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rst chk_valid", 32'(bus8.chk_valid), 32'd0);
        checkOutput("rst errs", 32'({bus8.nor_err, bus8.oai_err}), 32'd0);
        checkOutput("rst vec_cnt", 32'(bus8.vec_cnt), 32'd0);
        checkOutput("rst err_cnt", 32'(bus8.err_cnt), 32'd0);
        checkOutput("rst err_sticky", 32'(bus8.err_sticky), 32'd0);
        checkOutput("rst first_err_vec", 32'(bus8.first_err_vec), 32'd0);
        checkOutput("rst first_err_valid", 32'(bus8.first_err_valid), 32'd0);
        watchPulses(3, cnt, idx, nr, oa, st);
        checkOutput("rst hold pulse", 32'(cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        watchPulses(12, cnt, idx, nr, oa, st);
        checkOutput("post rst count", 32'(cnt), 32'd1);
        checkOutput("post rst edge", 32'(idx), 32'd9);
        checkOutput("post rst vec_cnt", 32'(bus8.vec_cnt), 32'd1);

        // 2-bit counters with five failing vectors saturate at 3.
        vec2[0] = 5'b10000; w1b[0] = 1'b1;
        vec2[1] = 5'b01000; w1b[1] = 1'b1;
        vec2[2] = 5'b11000; w1b[2] = 1'b1;
        vec2[3] = 5'b00001; w1b[3] = 1'b0;
        vec2[4] = 5'b00000; w1b[4] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            int   c2cnt;
            int   c2idx;
            logic c2nor;
            @(negedge clk);
            bus2.en = 1'b1;
            {bus2.a1, bus2.b1, bus2.a2, bus2.b2, bus2.c2} = vec2[k];
            bus2.w1 = w1b[k];
            bus2.w2 = 1'b1;
            c2cnt = 0;
            c2idx = -1;
            c2nor = 1'b0;
            for (int e = 0; e < 8; e++) begin
                @(posedge clk);
                #1;
                if (bus2.chk_valid) begin
                    c2cnt++;
                    if (c2idx < 0) c2idx = e;
                    c2nor = bus2.nor_err;
                end
            end
            checkOutput($sformatf("sat%0d pulse count", k), 32'(c2cnt), 32'd1);
            checkOutput($sformatf("sat%0d pulse edge", k), 32'(c2idx), 32'd4);
            checkOutput($sformatf("sat%0d nor_err", k), 32'(c2nor), 32'd1);
            checkOutput($sformatf("sat%0d vec_cnt", k), 32'(bus2.vec_cnt), (k < 3) ? 32'(k + 1) : 32'd3);
        end
        checkOutput("sat err_cnt", 32'(bus2.err_cnt), 32'd3);
        checkOutput("sat err_sticky", 32'(bus2.err_sticky), 32'd1);
        checkOutput("sat first_err_vec", 32'(bus2.first_err_vec), 32'(5'b10000));
        checkOutput("sat first_err_valid", 32'(bus2.first_err_valid), 32'd1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
